// File: rtl/crc16_frame_arbiter_if.sv
// rtl/crc16_frame_arbiter_if.sv - requester and output stream bundle for the CRC-16 frame arbiter
interface crc16_frame_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int SEL_W = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic               out_valid;
    logic [7:0]         out_data;
    logic               out_last;
    logic [SEL_W-1:0]   out_src;
    logic               out_ready;
    logic               busy;

    // Sources and sink side: drives requests and downstream ready.
    modport master (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_last, out_src, busy
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_last, out_src, busy
    );
endinterface

// File: rtl/crc16_frame_arbiter.sv
// rtl/crc16_frame_arbiter.sv - round-robin frame arbiter sharing one CRC-16/BUYPASS engine
module crc16_frame_arbiter #(
    parameter int N_REQ = 4,
    parameter int SEL_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    crc16_frame_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_CRC_HI = 2'd2,
        S_CRC_LO = 2'd3
    } state_t;

    state_t             r_state;
    logic [15:0]        r_crc;
    logic [SEL_W-1:0]   r_rr_ptr;
    logic [SEL_W-1:0]   r_grant;

    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic               w_found;
    logic [SEL_W:0]     w_sum;
    logic [SEL_W-1:0]   w_pick;
    logic               w_gvalid;
    logic [7:0]         w_gdata;
    logic               w_glast;
    logic               w_accept;

    // Fold one byte into the CRC, MSB first, polynomial 0x8005.
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] x;
        x = c ^ {d, 8'h00};
        for (int b = 0; b < 8; b++) begin
            x = x[15] ? ((x << 1) ^ 16'h8005) : (x << 1);
        end
        return x;
    endfunction

    // Rotate the request vector so bit 0 is the round-robin starting point.
    assign w_dbl = {bus.req_valid, bus.req_valid};
    assign w_rot = N_REQ'(w_dbl >> r_rr_ptr);

    // First requesting index at or after rr_ptr, translated back to an absolute index.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_rr_ptr} + (SEL_W+1)'(k);
                if (w_sum >= (SEL_W+1)'(N_REQ)) begin
                    w_sum = w_sum - (SEL_W+1)'(N_REQ);
                end
                w_pick = w_sum[SEL_W-1:0];
            end
        end
    end

    // Select the granted requester's byte lane.
    always_comb begin
        w_gvalid = 1'b0;
        w_gdata  = 8'h00;
        w_glast  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant == SEL_W'(i)) begin
                w_gvalid = bus.req_valid[i];
                w_gdata  = bus.req_data[8*i +: 8];
                w_glast  = bus.req_last[i];
            end
        end
    end

    assign w_accept = (r_state == S_DATA) && w_gvalid && bus.out_ready;

    // Frame sequencer: grant, payload with CRC folding, then two CRC bytes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_crc    <= 16'h0000;
            r_rr_ptr <= '0;
            r_grant  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_crc <= 16'h0000;
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_crc <= crc_byte(r_crc, w_gdata);
                        if (w_glast) begin
                            r_state <= S_CRC_HI;
                        end
                    end
                end
                S_CRC_HI: begin
                    if (bus.out_ready) begin
                        r_state <= S_CRC_LO;
                    end
                end
                S_CRC_LO: begin
                    if (bus.out_ready) begin
                        r_rr_ptr <= (r_grant == SEL_W'(N_REQ-1)) ? '0 : r_grant + SEL_W'(1);
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output mux: payload passes straight through, CRC bytes come from the register.
    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_data  = 8'h00;
        bus.out_last  = 1'b0;
        bus.req_ready = '0;
        case (r_state)
            S_DATA: begin
                bus.out_valid = w_gvalid;
                bus.out_data  = w_gdata;
                for (int i = 0; i < N_REQ; i++) begin
                    if (r_grant == SEL_W'(i)) begin
                        bus.req_ready[i] = bus.out_ready;
                    end
                end
            end
            S_CRC_HI: begin
                bus.out_valid = 1'b1;
                bus.out_data  = r_crc[15:8];
            end
            S_CRC_LO: begin
                bus.out_valid = 1'b1;
                bus.out_data  = r_crc[7:0];
                bus.out_last  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.out_src = r_grant;
    assign bus.busy    = (r_state != S_IDLE);

endmodule

// File: doc/crc16_frame_arbiter.md
# crc16_frame_arbiter

Round-robin arbiter and sequencer that shares one byte-parallel CRC-16 engine between `N_REQ` byte-stream requesters. It grants one requester per frame and passes that requester's bytes to a single output stream. Each byte is folded into the CRC, and two CRC bytes (MSB first) are appended after the requester's last byte. It sits between packet sources and the serial/link transmitter.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `SEL_W`, default 2: width of `out_src`; must equal clog2(`N_REQ`).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  `N_REQ`  per-requester byte valid.
- `req_data`  in  8*`N_REQ`  per-requester byte; requester i uses bits [8i+7:8i].
- `req_last`  in  `N_REQ`  marks the final payload byte of the frame.
- `req_ready`  out  `N_REQ`  per-requester byte accepted.
- `out_valid`  out  1  output byte valid.
- `out_data`  out  8  output byte (payload or CRC).
- `out_last`  out  1  high on the CRC low byte only.
- `out_src`  out  `SEL_W`  index of the granted requester, stable for the whole frame.
- `out_ready`  in  1  downstream accepts the byte.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- CRC: polynomial 0x8005 (x^16+x^15+x^2+1), init 0x0000, MSB-first, no reflection, no final XOR (CRC-16/BUYPASS). One byte is folded per accepted payload beat.
- States: IDLE, DATA, CRC_HI, CRC_LO.
- IDLE:
  - `crc` is held at 0x0000.
  - If any `req_valid` is set, grant the first set bit searching upward from `rr_ptr` with wrap-around. Register the grant, then go to DATA.
  - If no `req_valid` is set, stay in IDLE.
- DATA:
  - Outputs track the granted requester g: `out_valid`=`req_valid[g]`, `out_data`=`req_data[g]`, `out_last`=0.
  - `req_ready[g]`=`out_ready`. All other `req_ready` bits are 0.
  - A beat is accepted when `out_valid` and `out_ready` are both high. On each accepted beat, update `crc` with `out_data`.
  - If the accepted beat has `req_last[g]` set, go to CRC_HI.
- CRC_HI: `out_valid`=1, `out_data`=`crc[15:8]`, `out_last`=0. When `out_ready` is high, go to CRC_LO.
- CRC_LO: `out_valid`=1, `out_data`=`crc[7:0]`, `out_last`=1. When `out_ready` is high:
  - set `rr_ptr` to (g+1) mod `N_REQ`;
  - go to IDLE.
- `req_ready` is 0 for every requester in IDLE, CRC_HI and CRC_LO.
- The grant is held until the frame completes. `req_valid` dropping mid-frame is a bubble, not an abort.
- A granted requester that deasserts `req_valid` forever stalls the block. This is a documented hazard, not handled in hardware.

## Timing
- Reset values:
  - state=IDLE, `crc`=0x0000, `rr_ptr`=0, grant=0;
  - `out_valid`=0, `out_last`=0, `out_data`=0x00, `out_src`=0, `busy`=0, all `req_ready`=0.
- Reset asserted mid-frame: all of the above apply immediately, and the partial frame is lost. After release, arbitration restarts from requester 0.
- Arbitration costs exactly one cycle (IDLE). The first payload byte can be presented in the cycle after a request is seen.
- Payload path is combinational from `req_*` to `out_*`, and from `out_ready` to `req_ready`. The block adds no payload latency.
- The CRC bytes follow the last payload beat with zero bubbles if `out_ready` stays high. A frame of L bytes therefore occupies L+3 cycles including IDLE.
- With `out_ready` low, `out_data`/`out_last`/`out_src` hold stable while `out_valid`=1 (CRC states). The CRC is not updated.
- Back-to-back frames have exactly one idle cycle between the CRC_LO handshake and the next DATA state.
- If `req_valid` for a non-granted requester rises mid-frame, it is ignored until the next IDLE.

## Test plan
- Requester 0 sends ASCII "123456789" with `out_ready`=1 -> output is the 9 bytes, then 0xFE, 0xE8. `out_last` is high only on 0xE8, `out_src`=0, total 12 cycles from IDLE.
- Requester 2 sends the single byte 0x01 with last=1 -> output is 0x01, 0x80, 0x05. CRC is 0x8005 and `busy` drops the cycle after 0x05 is accepted.
- All four requesters hold 1-byte frames continuously -> grant order is 0,1,2,3,0. Each frame is separated by exactly one IDLE cycle.
- Frame "123456789" with `out_ready` toggled 1/0 every cycle -> same 11 output bytes and same CRC 0xFEE8. Data is stable while `out_ready`=0, and `req_ready[0]` mirrors `out_ready`.
- Assert `rst` low during byte 4 of a frame on requester 1, then release -> all outputs go to reset values asynchronously. A new "123456789" frame from requester 1 yields CRC 0xFEE8, proving `crc` was cleared.
- Requester 3 `req_valid` drops for 5 cycles mid-frame while requester 0 is valid -> no grant switch, `out_valid`=0 during the gap, and the CRC is unchanged by the bubble.
